// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types and opcode constants for the ALU issue scheduler and control unit.
package alu_sched_pkg;

  localparam int unsigned NUM_REGS_DEFAULT = 8;
  localparam int unsigned REG_W            = $clog2(NUM_REGS_DEFAULT);
  localparam int unsigned OPC_W            = 3;

  typedef logic [OPC_W-1:0] opcode_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam opcode_t OP_NOP = 3'b000;
  localparam opcode_t OP_ADD = 3'b001;
  localparam opcode_t OP_SUB = 3'b010;
  localparam opcode_t OP_AND = 3'b011;
  localparam opcode_t OP_OR  = 3'b100;

  typedef struct packed {
    opcode_t  opcode;
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
  } instr_t;

  // ALU ops read rs1/rs2 and write rd; everything else carries no operands.
  function automatic logic is_alu_op(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic is_illegal_op(input opcode_t op);
    return op > OP_OR;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Fetch-side handshake plus issue and writeback buses of the scheduler.
interface alu_issue_scheduler_if;
  import alu_sched_pkg::*;

  logic     in_valid;
  logic     in_ready;
  opcode_t  in_opcode;
  reg_idx_t in_rd;
  reg_idx_t in_rs1;
  reg_idx_t in_rs2;

  logic     issue_valid;
  opcode_t  issue_opcode;
  reg_idx_t issue_rd;
  reg_idx_t issue_rs1;
  reg_idx_t issue_rs2;

  logic     wb_valid;
  reg_idx_t wb_rd;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2,
    input  in_ready,
    input  issue_valid, issue_opcode, issue_rd, issue_rs1, issue_rs2,
    input  wb_valid, wb_rd
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2,
    output in_ready,
    output issue_valid, issue_opcode, issue_rd, issue_rs1, issue_rs2,
    output wb_valid, wb_rd
  );

endinterface

// File: rtl/alu_issue_scheduler_fifo.sv
// Synchronous instruction FIFO with flush; caller never pushes when full or pops when empty.
module sched_fifo
  import alu_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  instr_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output instr_t           head,
  output logic [CNT_W-1:0] count
);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers and entry count; flush drops every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// In-order ALU issue scheduler: FIFO, register scoreboard and fixed-latency writeback tracking.
module alu_issue_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int unsigned DEPTH    = 4,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter  int unsigned ALU_LAT  = 2,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  alu_issue_scheduler_if.slave  bus,
  output logic [CNT_W-1:0]      occupancy,
  output logic [15:0]           stall_cnt,
  output logic                  illegal_seen
);

  instr_t                        head;
  instr_t                        push_data;
  logic [CNT_W-1:0]              count;
  logic                          head_valid;
  logic                          head_alu;
  logic                          push;
  logic                          illegal_in;
  logic                          blocked;
  logic                          issue_go;
  logic [NUM_REGS-1:0]           pending_q;
  logic [NUM_REGS-1:0]           pending_d;
  logic [NUM_REGS-1:0]           release_mask;
  logic [NUM_REGS-1:0]           pending_eff;
  logic [ALU_LAT-1:0]            pipe_v;
  logic [ALU_LAT-1:0][REG_W-1:0] pipe_rd;

  assign bus.in_ready = (count < CNT_W'(DEPTH)) && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign illegal_in   = is_illegal_op(bus.in_opcode);
  assign push_data    = '{opcode: illegal_in ? OP_NOP : bus.in_opcode,
                          rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2};
  assign head_valid   = (count != '0);
  assign head_alu     = is_alu_op(head.opcode);
  assign occupancy    = count;

  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (issue_go),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  // Hazard check against pending regs, releasing the register whose writeback lands next cycle.
  always_comb begin
    release_mask = '0;
    if (pipe_v[ALU_LAT-1]) release_mask[pipe_rd[ALU_LAT-1]] = 1'b1;
    pending_eff = pending_q & ~release_mask;
    blocked     = head_alu && (pending_eff[head.rs1] || pending_eff[head.rs2] ||
                               pending_eff[head.rd]);
    issue_go    = head_valid && !blocked && !flush;
    pending_d   = pending_eff;
    if (issue_go && head_alu) pending_d[head.rd] = 1'b1;
  end

  // Registered issue port; fields hold while nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.issue_valid  <= 1'b0;
      bus.issue_opcode <= OP_NOP;
      bus.issue_rd     <= '0;
      bus.issue_rs1    <= '0;
      bus.issue_rs2    <= '0;
    end else begin
      bus.issue_valid <= issue_go;
      if (issue_go) begin
        bus.issue_opcode <= head.opcode;
        bus.issue_rd     <= head.rd;
        bus.issue_rs1    <= head.rs1;
        bus.issue_rs2    <= head.rs2;
      end
    end
  end

  // Scoreboard of destination registers with writes in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Writeback shift pipeline; stage 0 lines up with issue_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v       <= '0;
      pipe_rd      <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= '0;
    end else begin
      pipe_v[0]  <= issue_go && head_alu;
      pipe_rd[0] <= head.rd;
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_rd[i] <= pipe_rd[i-1];
      end
      bus.wb_valid <= pipe_v[ALU_LAT-1];
      if (pipe_v[ALU_LAT-1]) bus.wb_rd <= pipe_rd[ALU_LAT-1];
    end
  end

  // Saturating stall counter and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      illegal_seen <= 1'b0;
    end else begin
      if (head_valid && blocked && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (push && illegal_in) illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler with an issue/writeback scoreboard.
module tb_alu_issue_scheduler;
  import alu_sched_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int          ALU_LAT = 2;

  typedef struct {
    reg_idx_t rd;
    int       due;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        illegal_seen;

  alu_issue_scheduler_if bus();

  alu_issue_scheduler #(.DEPTH(DEPTH), .NUM_REGS(8), .ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .occupancy    (occupancy),
    .stall_cnt    (stall_cnt),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  instr_t expq[$];
  wb_t    wbq[$];
  int     cyc;
  int     n_cmp;
  int     n_err;
  int     guard;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input opcode_t op, input reg_idx_t rd,
                       input reg_idx_t rs1, input reg_idx_t rs2);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_issue_valid"}, 32'(bus.issue_valid), 32'd0);
    chk({tag, "_issue_opcode"}, 32'(bus.issue_opcode), 32'd0);
    chk({tag, "_issue_rd"}, 32'(bus.issue_rd), 32'd0);
    chk({tag, "_issue_rs1"}, 32'(bus.issue_rs1), 32'd0);
    chk({tag, "_issue_rs2"}, 32'(bus.issue_rs2), 32'd0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_illegal_seen"}, 32'(illegal_seen), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // One clock: check handshake, advance, then check writeback, issue order and occupancy.
  task automatic step();
    logic   exp_rdy;
    logic   acc;
    logic   fl;
    instr_t ins;
    instr_t e;
    #1;
    exp_rdy = (expq.size() < DEPTH) && !flush;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    fl  = flush;
    ins = '{opcode: (bus.in_opcode > OP_OR) ? OP_NOP : bus.in_opcode,
            rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2};
    @(posedge clk);
    #1;
    cyc++;
    if (wbq.size() != 0 && wbq[0].due == cyc) begin
      chk("wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("wb_rd", 32'(bus.wb_rd), 32'(wbq[0].rd));
      void'(wbq.pop_front());
    end else begin
      chk("wb_valid", 32'(bus.wb_valid), 32'd0);
    end
    if (bus.issue_valid) begin
      if (expq.size() == 0) begin
        chk("issue_unexpected", 32'(bus.issue_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("issue_opcode", 32'(bus.issue_opcode), 32'(e.opcode));
        chk("issue_rd", 32'(bus.issue_rd), 32'(e.rd));
        chk("issue_rs1", 32'(bus.issue_rs1), 32'(e.rs1));
        chk("issue_rs2", 32'(bus.issue_rs2), 32'(e.rs2));
        if (e.opcode >= OP_ADD && e.opcode <= OP_OR)
          wbq.push_back(wb_t'{rd: e.rd, due: cyc + ALU_LAT});
      end
    end
    if (fl) expq.delete();
    else if (acc) expq.push_back(ins);
    chk("occupancy", 32'(occupancy), 32'(expq.size()));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    flush = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst_n = 1'b1;

    // Four independent ADDs back to back.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, OP_ADD, 3'(k), 3'(k + 1), 3'(k + 2));
      step();
      chk("t1_issue_valid", 32'(bus.issue_valid), (k > 1) ? 32'd1 : 32'd0);
    end
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t1_issue_last", 32'(bus.issue_valid), 32'd1);
    repeat (4) step();
    chk("t1_stall", 32'(stall_cnt), 32'd0);

    // RAW with zero-bubble release.
    drive(1'b1, OP_ADD, 3'd1, 3'd2, 3'd3);
    step();
    drive(1'b1, OP_SUB, 3'd4, 3'd1, 3'd5);
    step();
    chk("t2_add_issue", 32'(bus.issue_valid), 32'd1);
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t2_sub_blocked", 32'(bus.issue_valid), 32'd0);
    step();
    chk("t2_sub_issue", 32'(bus.issue_valid), 32'd1);
    chk("t2_wb_same_cycle", 32'(bus.wb_valid), 32'd1);
    chk("t2_wb_rd", 32'(bus.wb_rd), 32'd1);
    chk("t2_stall", 32'(stall_cnt), 32'd1);
    repeat (4) step();

    // WAW: the new pending bit must survive the overlapping writeback.
    drive(1'b1, OP_OR, 3'd2, 3'd6, 3'd7);
    step();
    drive(1'b1, OP_AND, 3'd2, 3'd6, 3'd7);
    step();
    chk("t3_or_issue", 32'(bus.issue_valid), 32'd1);
    drive(1'b1, OP_ADD, 3'd3, 3'd2, 3'd0);
    step();
    chk("t3_and_blocked", 32'(bus.issue_valid), 32'd0);
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t3_and_issue", 32'(bus.issue_valid), 32'd1);
    chk("t3_and_opcode", 32'(bus.issue_opcode), 32'(OP_AND));
    step();
    chk("t3_set_wins", 32'(bus.issue_valid), 32'd0);
    step();
    chk("t3_add_issue", 32'(bus.issue_valid), 32'd1);
    chk("t3_stall", 32'(stall_cnt), 32'd3);
    repeat (4) step();

    // Illegal opcode is issued as NOP; NOP ignores the scoreboard.
    drive(1'b1, 3'b110, 3'd1, 3'd2, 3'd3);
    step();
    chk("t5_illegal_seen", 32'(illegal_seen), 32'd1);
    drive(1'b1, OP_ADD, 3'd5, 3'd0, 3'd0);
    step();
    drive(1'b1, OP_NOP, 3'd5, 3'd5, 3'd5);
    step();
    chk("t5_add_issue", 32'(bus.issue_valid), 32'd1);
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t5_nop_issue", 32'(bus.issue_valid), 32'd1);
    chk("t5_nop_opcode", 32'(bus.issue_opcode), 32'(OP_NOP));
    repeat (4) step();
    chk("t5_illegal_sticky", 32'(illegal_seen), 32'd1);
    chk("t5_stall", 32'(stall_cnt), 32'd3);

    // Flush with three queued and one ALU op in flight.
    drive(1'b1, OP_ADD, 3'd1, 3'd2, 3'd3);
    step();
    drive(1'b1, OP_ADD, 3'd1, 3'd2, 3'd3);
    step();
    drive(1'b1, OP_SUB, 3'd4, 3'd1, 3'd1);
    step();
    step();
    chk("t6_inflight_issue", 32'(bus.issue_valid), 32'd1);
    step();
    chk("t6_queued", 32'(occupancy), 32'd3);
    flush = 1'b1;
    drive(1'b1, OP_ADD, 3'd6, 3'd6, 3'd6);
    step();
    chk("t6_flush_occ", 32'(occupancy), 32'd0);
    chk("t6_flush_issue", 32'(bus.issue_valid), 32'd0);
    chk("t6_flush_wb", 32'(bus.wb_valid), 32'd1);
    chk("t6_flush_wb_rd", 32'(bus.wb_rd), 32'd1);
    flush = 1'b0;
    drive(1'b1, OP_SUB, 3'd4, 3'd1, 3'd1);
    step();
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t6_pending_cleared", 32'(bus.issue_valid), 32'd1);
    chk("t6_stall", 32'(stall_cnt), 32'd5);
    repeat (4) step();

    // Fill the FIFO behind a dependency chain; full blocks enqueue.
    drive(1'b1, OP_AND, 3'd7, 3'd7, 3'd7);
    guard = 0;
    while (occupancy != 3'(DEPTH) && guard < 20) begin
      step();
      guard++;
    end
    chk("t4_full_occ", 32'(occupancy), 32'(DEPTH));
    chk("t4_full_ready", 32'(bus.in_ready), 32'd0);
    repeat (6) step();
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    repeat (30) step();
    chk("t4_drained", 32'(occupancy), 32'd0);

    // Asynchronous reset with a write in flight.
    drive(1'b1, OP_ADD, 3'd1, 3'd2, 3'd3);
    step();
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t7_pre_issue", 32'(bus.issue_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    expq.delete();
    wbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, OP_SUB, 3'd2, 3'd1, 3'd1);
    step();
    drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0);
    step();
    chk("t7_post_issue", 32'(bus.issue_valid), 32'd1);
    chk("t7_post_stall", 32'(stall_cnt), 32'd0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
- In-order issue scheduler between instruction fetch and high_perf_control_unit.
- Buffers incoming ALU instructions in a small FIFO.
- Tracks outstanding destination registers in a scoreboard.
- Issues at most one hazard-free instruction per cycle to the decode/ALU path, and retires writebacks after a fixed ALU latency.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, ≥2).
- NUM_REGS, 8, architectural registers tracked; register index width = log2(NUM_REGS).
- ALU_LAT, 2, cycles from issue_valid to the matching wb_valid (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  scheduler can accept; transfer when in_valid & in_ready at posedge.
- in_opcode  in  3  opcode: NOP=000, ADD=001, SUB=010, AND=011, OR=100.
- in_rd  in  log2(NUM_REGS)  destination register.
- in_rs1  in  log2(NUM_REGS)  source register 1.
- in_rs2  in  log2(NUM_REGS)  source register 2.
- flush  in  1  discard all queued, unissued instructions.
- issue_valid  out  1  registered; one instruction presented to control unit this cycle.
- issue_opcode  out  3  registered opcode to control unit.
- issue_rd, issue_rs1, issue_rs2  out  log2(NUM_REGS) each  registered operand indices.
- wb_valid  out  1  writeback of an issued ALU op completes this cycle.
- wb_rd  out  log2(NUM_REGS)  register being written back.
- occupancy  out  log2(DEPTH)+1  FIFO entry count.
- stall_cnt  out  16  saturating count of cycles the head was valid but blocked.
- illegal_seen  out  1  sticky; set when an opcode 101–111 is accepted.

Behaviour:
- Reset values: issue_valid=0, issue_opcode=000, issue_rd/rs1/rs2=0, wb_valid=0, wb_rd=0, occupancy=0, stall_cnt=0, illegal_seen=0, all scoreboard bits clear, wb pipeline empty, in_ready=1.
- Reset asserted mid-operation clears everything immediately; in-flight writebacks are lost.
- FIFO and handshake:
  - in_ready = (occupancy < DEPTH) & ~flush. There is no combinational path from issue to in_ready, so a full FIFO cannot enqueue even on a dequeue cycle.
  - Enqueue and dequeue in the same cycle leave occupancy unchanged.
  - There is no bypass: an instruction accepted at edge t reaches issue_valid at edge t+1 at the earliest.
- Classification:
  - ALU ops (001–100) read rs1 and rs2 and write rd.
  - NOP (000) has no operands and no hazard check.
  - Illegal opcodes (101–111) are accepted, set illegal_seen, and are stored and issued as NOP (issue_opcode=000).
- Hazard check, head ALU op:
  - The head is blocked if pending[rs1], pending[rs2] or pending[rd] is set (RAW/WAW).
  - pending is evaluated after this cycle's writeback clear: a wb_valid on register r in cycle c allows an instruction using r to issue in cycle c (zero-bubble release).
- Issue:
  - Head not blocked and FIFO non-empty: dequeue; next cycle issue_valid=1 with the head fields. Otherwise issue_valid=0 next cycle.
  - issue_* fields hold their last value while issue_valid=0.
- Scoreboard:
  - Issuing an ALU op sets pending[rd] and pushes {1, rd} into an ALU_LAT-deep shift pipeline aligned to issue_valid.
  - The pipeline output drives wb_valid/wb_rd and clears pending[wb_rd].
  - When a set and a clear hit the same register in the same cycle, the set wins.
- stall_cnt increments each cycle the FIFO is non-empty and the head is blocked; it saturates at 0xFFFF.
- flush:
  - Next edge: FIFO empties (occupancy=0) and issue_valid=0.
  - An instruction already on issue_valid and the wb pipeline are not cancelled; the scoreboard drains normally.
  - in_valid is ignored in the flush cycle.
- Simultaneous flush and writeback: both take effect.

Decomposition:
- Package alu_sched_pkg holds:
  - opcode constants (shared with high_perf_control_unit);
  - is_alu_op function;
  - instr_t packed struct {opcode, rd, rs1, rs2};
  - NUM_REGS default.
- Sub-module sched_fifo: parameterised DEPTH synchronous FIFO of instr_t with push/pop/flush/count.
- Scoreboard and wb pipeline stay in the top module.

Test Plan:
- Reset, then 4 back-to-back independent ADDs (r1←r2,r3 … r4←r5,r6) -> issue_valid high 4 consecutive cycles starting cycle after first accept; wb_valid for rd=1..4 exactly 2 cycles after each issue.
- ADD r1←r2,r3 then SUB r4←r1,r5 -> SUB issues in the same cycle wb_valid&wb_rd=1 (zero-bubble), i.e. 2 cycles after ADD issue; stall_cnt=1.
- WAW: OR r2 then AND r2 back-to-back -> AND blocked until r2 writeback; pending[r2] remains set through the overlap cycle (set wins).
- Fill: hold head blocked, push 5 instructions -> in_ready=0 after 4th, occupancy=4, 5th not accepted until a dequeue.
- Opcode 110 accepted -> illegal_seen=1 sticky, issued as issue_opcode=000, no wb_valid; NOP 000 issues without checking scoreboard.
- flush with 3 queued and 1 in flight -> occupancy=0 and issue_valid=0 next cycle; the in-flight wb_valid still appears and clears its pending bit. Separately, rst_n asserted with pending bits set -> all outputs return to reset values asynchronously.
